// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: types and helpers shared by the FIFO-side arbiters.
package fifo_arb_pkg;

   typedef enum logic {IDLE, BURST} arb_state_t;

   localparam int STAT_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search, first set request at or above rr_ptr with wrap.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   output logic [N-1:0]  pick,
   output logic          found
);

   logic [PW-1:0] w_idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      w_idx = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = PW'((int'(rr_ptr) + k) % N);
         if (!found && req[w_idx]) begin
            pick[w_idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the dual_clk_fifo write port.
// Define FIFO_WR_ARB_STATS_EN to add per-requester word counters and a stall counter.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATESIZE  = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                        wclk,
   input  logic                        wrst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATESIZE-1:0] req_data,
   input  logic                        wfull,
   input  logic                        almost_full,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        winc,
   output logic [DATESIZE-1:0]         wdata,
   output logic [NUM_REQ-1:0]          grant,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic                        stat_clr,
   output logic [NUM_REQ*STAT_W-1:0]   stat_words,
   output logic [STAT_W-1:0]           stat_stall,
`endif
   output logic                        busy
);

   localparam int PW = clog2(NUM_REQ);
   localparam int CW = clog2(BURST_LEN + 1);

   arb_state_t         r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt, w_pick;
   logic [PW-1:0]      r_gidx, w_gidx_nxt, r_rr_ptr, w_rr_ptr_nxt, w_pick_idx;
   logic [CW-1:0]      r_burst_cnt, w_burst_cnt_nxt;
   logic               w_found, w_last;

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .pick   (w_pick),
      .found  (w_found)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (w_pick[k]) w_pick_idx = PW'(k);
   end

   // busy implies a non-zero grant, so gating on it keeps the write port quiet when idle
   assign busy   = (r_state == BURST);
   assign grant  = r_grant;
   assign winc   = busy & req[r_gidx] & ~wfull;
   assign ack    = winc ? r_grant : '0;
   assign wdata  = busy ? req_data[int'(r_gidx)*DATESIZE +: DATESIZE] : '0;
   assign w_last = winc && (r_burst_cnt == CW'(BURST_LEN - 1));

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_gidx_nxt      = r_gidx;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_burst_cnt_nxt = r_burst_cnt;
      if (r_state == IDLE) begin
         if (w_found && !almost_full && !wfull) begin
            w_state_nxt     = BURST;
            w_grant_nxt     = w_pick;
            w_gidx_nxt      = w_pick_idx;
            w_burst_cnt_nxt = '0;
         end
      end else if (w_last || !req[r_gidx]) begin
         w_state_nxt  = IDLE;
         w_grant_nxt  = '0;
         w_rr_ptr_nxt = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
      end else if (winc) begin
         w_burst_cnt_nxt = r_burst_cnt + 1'b1;
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_gidx      <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_gidx      <= w_gidx_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat_stall;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      logic [STAT_W-1:0] r_cnt;
      always_ff @(posedge wclk) begin
         if (wrst || stat_clr) r_cnt <= '0;
         else if (ack[g] && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
      assign stat_words[g*STAT_W +: STAT_W] = r_cnt;
   end

   always_ff @(posedge wclk) begin
      if (wrst || stat_clr) r_stat_stall <= '0;
      else if (busy && wfull && r_stat_stall != '1) r_stat_stall <= r_stat_stall + 1'b1;
   end

   assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of bursts, round-robin order, stalls, holds and reset.
module tb_fifo_wr_arbiter;

   logic        wclk = 1'b0;
   logic        wrst, wfull, almost_full, winc, busy;
   logic [3:0]  req, ack, grant, g_exp;
   logic [31:0] req_data;
   logic [7:0]  wdata;
`ifdef FIFO_WR_ARB_STATS_EN
   logic        stat_clr;
   logic [63:0] stat_words;
   logic [15:0] stat_stall;
`endif

   int         n_chk = 0;
   int         n_pass = 0;
   int         k0, n_ack;
   logic [7:0] wq[$];
   logic [7:0] byte_of [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
   logic [10:0] w1_pat = 11'b01111011110;
   logic [8:0]  w3_pat = 9'b011000110;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATESIZE(8), .BURST_LEN(4)) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .req         (req),
      .req_data    (req_data),
      .wfull       (wfull),
      .almost_full (almost_full),
      .ack         (ack),
      .winc        (winc),
      .wdata       (wdata),
      .grant       (grant),
`ifdef FIFO_WR_ARB_STATS_EN
      .stat_clr    (stat_clr),
      .stat_words  (stat_words),
      .stat_stall  (stat_stall),
`endif
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst = 1'b1; req = '0; wfull = 1'b0; almost_full = 1'b0;
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   initial begin
      wrst = 1'b1; req = '0; req_data = 32'hD3C2B1A0; wfull = 1'b0; almost_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (2) @(negedge wclk);
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_winc", winc, 0);
      chk("rst_ack", ack, 0);
      chk("rst_wdata", wdata, 0);
      wrst = 1'b0;

      // single requester streaming 0x10..0x17
      k0 = 0;
      for (int c = 0; c <= 10; c++) begin
         @(negedge wclk);
         req = (c < 10) ? 4'b0001 : 4'b0000;
         req_data[7:0] = 8'h10 + 8'(k0);
         #1;
         chk("t1_winc", winc, w1_pat[c]);
         chk("t1_grant", grant, w1_pat[c] ? 4'b0001 : 4'b0000);
         if (winc) begin
            wq.push_back(wdata);
            k0++;
         end
      end
      chk("t1_count", wq.size(), 8);
      for (int i = 0; i < 8 && i < wq.size(); i++) chk("t1_data", wq[i], 8'h10 + i);
      req_data[7:0] = 8'hA0;

      // all requesters busy: rotating 4-word bursts with one idle cycle between
      do_reset();
      for (int c = 0; c <= 25; c++) begin
         @(negedge wclk);
         req = (c < 25) ? 4'b1111 : 4'b0000;
         #1;
         g_exp = (c % 5 == 0) ? 4'b0000 : 4'b0001 << ((c / 5) % 4);
         chk("t2_grant", grant, g_exp);
         chk("t2_ack", ack, g_exp);
         chk("t2_wdata", wdata, (c % 5 == 0) ? 8'h00 : byte_of[(c / 5) % 4]);
      end

      // wfull for 3 cycles after the 2nd word of a burst by requester 1
      n_ack = 0;
      for (int c = 0; c <= 8; c++) begin
         @(negedge wclk);
         req = (c < 8) ? 4'b0010 : 4'b0000;
         wfull = (c >= 3 && c <= 5);
         #1;
         chk("t3_winc", winc, w3_pat[c]);
         chk("t3_grant", grant, (c >= 1 && c <= 7) ? 4'b0010 : 4'b0000);
         if (ack[1]) n_ack++;
      end
      chk("t3_acks", n_ack, 4);

      // almost_full blocks a new grant until it drops
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         @(negedge wclk);
         req = (c < 5) ? 4'b0110 : 4'b0000;
         almost_full = (c < 3);
         #1;
         chk("t4_grant", grant, (c == 4 || c == 5) ? 4'b0010 : 4'b0000);
         chk("t4_winc", winc, c == 4);
      end

      // requester 2 leaves after one word (with wfull), pointer moves to 3, then reset mid-burst
      @(negedge wclk); req = 4'b0100; #1;
      chk("t5_idle", grant, 4'b0000);
      @(negedge wclk); #1;
      chk("t5_ack", ack, 4'b0100);
      chk("t5_wdata", wdata, 8'hC2);
      @(negedge wclk); req = 4'b0000; wfull = 1'b1; #1;
      chk("t5_drop_grant", grant, 4'b0100);
      chk("t5_drop_winc", winc, 0);
      @(negedge wclk); req = 4'b1101; wfull = 1'b0; #1;
      chk("t5_exit", grant, 4'b0000);
      @(negedge wclk); #1;
      chk("t5_next_grant", grant, 4'b1000);
      chk("t5_next_wdata", wdata, 8'hD3);
      @(negedge wclk); wrst = 1'b1; #1;
      chk("t5_pre_rst_winc", winc, 1);
      @(negedge wclk); wrst = 1'b0; #1;
      chk("t5_rst_grant", grant, 4'b0000);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_winc", winc, 0);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("t5_stat_words", 32'(stat_words == '0), 1);
      chk("t5_stat_stall", stat_stall, 0);
`endif
      @(negedge wclk); #1;
      chk("t5_restart", grant, 4'b0001);
      chk("t5_restart_wdata", wdata, 8'hA0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
